// File: rtl/regfile_check_monitor_pkg.sv
// Shared definitions for the regfile self-check monitor: FSM encoding and default widths.
package regfile_check_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefRegAw = 5;
  localparam int unsigned DefDataW = 32;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_check_monitor_shadow_regfile.sv
// Shadow copy of the processor register file: one write port with bulk clear, one async read port.
module regfile_check_monitor_shadow_regfile
  import regfile_check_monitor_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, and reads of it are forced to zero as well.
  assign rdata = (raddr == '0) ? '0 : mem_q[raddr];

endmodule

// File: rtl/regfile_check_monitor.sv
// On-chip self-check monitor: mirrors regfile writes during a run window, then checks a
// table of expected (reg, value) pairs one per cycle and reports the result.
module regfile_check_monitor
  import regfile_check_monitor_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned REG_AW      = DefRegAw,
  parameter int unsigned NUM_CHECKS  = 6,
  parameter int unsigned CYCLE_LIMIT = 20,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         halt,
  input  logic                         ctrl_writeEnable,
  input  logic [REG_AW-1:0]            ctrl_writeReg,
  input  logic [DATA_W-1:0]            data_writeReg,
  input  logic [NUM_CHECKS-1:0]        exp_valid,
  input  logic [NUM_CHECKS*REG_AW-1:0] exp_reg_flat,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_val_flat,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [CNT_W-1:0]             error_count,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [7:0]                   first_fail_idx,
  output logic [DATA_W-1:0]            first_fail_val
);

  localparam int unsigned IDX_W = idx_width(NUM_CHECKS);
  localparam int unsigned RUN_W = idx_width(CYCLE_LIMIT);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CHECKS - 1);
  localparam logic [RUN_W-1:0] RunLast = RUN_W'(CYCLE_LIMIT - 1);

  state_e            state_q;
  logic              busy_q, done_q, pass_q;
  logic [RUN_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  cycle_count_q, error_count_q;
  logic [IDX_W-1:0]  idx_q, ff_idx_q;
  logic [DATA_W-1:0] ff_val_q;

  logic [REG_AW-1:0] exp_reg [NUM_CHECKS];
  logic [DATA_W-1:0] exp_val [NUM_CHECKS];

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_exp
    assign exp_reg[i] = exp_reg_flat[i*REG_AW +: REG_AW];
    assign exp_val[i] = exp_val_flat[i*DATA_W +: DATA_W];
  end

  logic              start_run, run_end, sh_we, mismatch;
  logic [DATA_W-1:0] rd_data;

  assign start_run = start && ((state_q == StIdle) || (state_q == StDone));
  // Run length uses its own counter so a narrow, saturating cycle_count cannot shorten the window.
  assign run_end   = (state_q == StRun) && (halt || (run_cnt_q == RunLast));
  assign sh_we     = (state_q == StRun) && ctrl_writeEnable;
  assign mismatch  = (state_q == StCheck) && exp_valid[idx_q] && (rd_data != exp_val[idx_q]);

  regfile_check_monitor_shadow_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_shadow (
    .clock (clock),
    .reset (reset),
    .clear (start_run),
    .we    (sh_we),
    .waddr (ctrl_writeReg),
    .wdata (data_writeReg),
    .raddr (exp_reg[idx_q]),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      run_cnt_q     <= '0;
      cycle_count_q <= '0;
      error_count_q <= '0;
      idx_q         <= '0;
      ff_idx_q      <= '0;
      ff_val_q      <= '0;
    end else if (start_run) begin
      state_q       <= StRun;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      run_cnt_q     <= '0;
      cycle_count_q <= '0;
      error_count_q <= '0;
      idx_q         <= '0;
      ff_idx_q      <= '0;
      ff_val_q      <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + CNT_W'(1);
          if (run_end) state_q <= StCheck;
          else         run_cnt_q <= run_cnt_q + RUN_W'(1);
        end
        StCheck: begin
          if (mismatch) begin
            if (error_count_q != '1) error_count_q <= error_count_q + CNT_W'(1);
            if (error_count_q == '0) begin
              ff_idx_q <= idx_q;
              ff_val_q <= rd_data;
            end
          end
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (error_count_q == '0) && !mismatch;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = error_count_q;
  assign cycle_count    = cycle_count_q;
  assign first_fail_idx = 8'(ff_idx_q);
  assign first_fail_val = ff_val_q;

endmodule

// File: tb/tb_regfile_check_monitor.sv
// Directed bench for regfile_check_monitor with a reference shadow model and result scoreboard.
module tb_regfile_check_monitor;

  localparam int NC = 6;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 20;

  logic clock, reset, start, halt;
  logic ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [NC-1:0] exp_valid;
  logic [NC*AW-1:0] exp_reg_flat;
  logic [NC*DW-1:0] exp_val_flat;

  logic busy, done, pass;
  logic [15:0] error_count, cycle_count;
  logic [7:0] first_fail_idx;
  logic [DW-1:0] first_fail_val;

  logic busy2, done2, pass2;
  logic [1:0] error_count2, cycle_count2;
  logic [7:0] first_fail_idx2;
  logic [DW-1:0] first_fail_val2;

  regfile_check_monitor dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .exp_valid(exp_valid), .exp_reg_flat(exp_reg_flat),
    .exp_val_flat(exp_val_flat), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .cycle_count(cycle_count),
    .first_fail_idx(first_fail_idx), .first_fail_val(first_fail_val)
  );

  regfile_check_monitor #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .exp_valid(exp_valid), .exp_reg_flat(exp_reg_flat),
    .exp_val_flat(exp_val_flat), .busy(busy2), .done(done2), .pass(pass2),
    .error_count(error_count2), .cycle_count(cycle_count2),
    .first_fail_idx(first_fail_idx2), .first_fail_val(first_fail_val2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] err;
    logic [7:0]  idx;
    logic [31:0] val;
    logic        pas;
    logic [15:0] cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          run_left = 0;
  logic [15:0] cyc_m = '0;
  logic [31:0] shadow_m [32];
  logic [4:0]  t_reg [NC];
  logic [31:0] t_val [NC];
  logic [NC-1:0] t_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model advances only while the bench believes the DUT is in its run window.
  task automatic tick();
    if (run_left > 0) begin
      if (ctrl_writeEnable && (ctrl_writeReg != 5'd0)) shadow_m[ctrl_writeReg] = data_writeReg;
      cyc_m++;
      run_left = halt ? 0 : run_left - 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [4:0] r, input logic [31:0] v);
    t_reg[i] = r;
    t_val[i] = v;
    exp_reg_flat[i*AW +: AW] = r;
    exp_val_flat[i*DW +: DW] = v;
  endtask

  task automatic set_valid(input logic [NC-1:0] v);
    t_valid = v;
    exp_valid = v;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) shadow_m[i] = '0;
    run_left = LIMIT;
    cyc_m = '0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = r;
    data_writeReg = v;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic run_until(input int left);
    while (run_left > left) tick();
  endtask

  function automatic exp_t eval_model();
    exp_t e;
    logic [31:0] got;
    e = '0;
    e.cyc = cyc_m;
    for (int i = 0; i < NC; i++) begin
      if (t_valid[i]) begin
        got = (t_reg[i] == 5'd0) ? 32'd0 : shadow_m[t_reg[i]];
        if (got !== t_val[i]) begin
          if (e.err == 16'd0) begin
            e.idx = 8'(i);
            e.val = got;
          end
          if (e.err != 16'hFFFF) e.err++;
        end
      end
    end
    e.pas = (e.err == 16'd0);
    return e;
  endfunction

  task automatic push_expected();
    sb_q.push_back(eval_model());
  endtask

  task automatic finish_run(input string tag, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    e = sb_q.pop_front();
    check({tag, "_err"}, 32'(error_count), 32'(e.err));
    check({tag, "_ffidx"}, 32'(first_fail_idx), 32'(e.idx));
    check({tag, "_ffval"}, first_fail_val, e.val);
    check({tag, "_pass"}, 32'(pass), 32'(e.pas));
    check({tag, "_cyc"}, 32'(cycle_count), 32'(e.cyc));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    exp_valid = '0;
    exp_reg_flat = '0;
    exp_val_flat = '0;
    t_valid = '0;
    for (int i = 0; i < 32; i++) shadow_m[i] = '0;
    for (int i = 0; i < NC; i++) set_entry(i, 5'd0, 32'd0);
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_cyc", 32'(cycle_count), 32'd0);
    check("rst_ffval", first_fail_val, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Test 1: clean run, with a stray start during RUN that must be ignored.
    set_entry(0, 5'd1, 32'd3);
    set_entry(1, 5'd2, 32'd3);
    set_entry(2, 5'd3, 32'd6);
    set_entry(3, 5'd7, 32'd0);
    set_entry(4, 5'd8, 32'd0);
    set_entry(5, 5'd9, 32'd999);
    set_valid(6'b111111);
    start_run();
    check("t1_busy", 32'(busy), 32'd1);
    wr(5'd1, 32'd3);
    wr(5'd2, 32'd3);
    wr(5'd3, 32'd6);
    wr(5'd9, 32'd999);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until(0);
    check("t1_cyc_at_check", 32'(cycle_count), 32'd20);
    push_expected();
    finish_run("t1", 6);
    check("t1_pass_fixed", 32'(pass), 32'd1);

    // Test 2: r3 holds 5 instead of 6, started from DONE.
    start_run();
    wr(5'd1, 32'd3);
    wr(5'd2, 32'd3);
    wr(5'd3, 32'd5);
    wr(5'd9, 32'd999);
    run_until(0);
    push_expected();
    finish_run("t2", 6);
    check("t2_ffidx_fixed", 32'(first_fail_idx), 32'd2);
    check("t2_ffval_fixed", first_fail_val, 32'd5);

    // Test 3: restart from DONE clears everything; r0 write dropped; last-cycle write kept.
    set_entry(0, 5'd0, 32'd0);
    set_entry(1, 5'd4, 32'h1234);
    set_entry(2, 5'd5, 32'd0);
    set_entry(3, 5'd9, 32'd0);
    set_entry(4, 5'd3, 32'd0);
    set_entry(5, 5'd1, 32'd0);
    start_run();
    check("t3_clr_err", 32'(error_count), 32'd0);
    check("t3_clr_ffidx", 32'(first_fail_idx), 32'd0);
    check("t3_clr_ffval", first_fail_val, 32'd0);
    check("t3_clr_done", 32'(done), 32'd0);
    check("t3_clr_cyc", 32'(cycle_count), 32'd0);
    wr(5'd0, 32'hDEADBEEF);
    run_until(1);
    wr(5'd4, 32'h1234);
    push_expected();
    wr(5'd5, 32'h55);
    finish_run("t3", 5);
    check("t3_pass_fixed", 32'(pass), 32'd1);

    // Test 4: halt on RUN cycle 4; only entry 0 is enabled.
    set_entry(0, 5'd1, 32'd7);
    for (int i = 1; i < NC; i++) set_entry(i, 5'(i + 1), 32'hBAD0 + 32'(i));
    set_valid(6'b000001);
    start_run();
    wr(5'd1, 32'd7);
    tick();
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t4_cyc", 32'(cycle_count), 32'd5);
    check("t4_busy", 32'(busy), 32'd1);
    push_expected();
    finish_run("t4", 6);

    // Test 5: reset in the middle of CHECK with errors already counted.
    for (int i = 0; i < NC; i++) set_entry(i, 5'(i + 1), 32'h100 + 32'(i));
    set_valid(6'b111111);
    start_run();
    run_until(0);
    tick();
    tick();
    check("t5_err_pre", 32'(error_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err", 32'(error_count), 32'd0);
    check("t5_cyc", 32'(cycle_count), 32'd0);
    check("t5_ffidx", 32'(first_fail_idx), 32'd0);
    check("t5_ffval", first_fail_val, 32'd0);
    check("t5_done", 32'(done), 32'd0);
    for (int i = 0; i < 32; i++) shadow_m[i] = '0;
    run_left = 0;
    #1;
    reset = 1'b1;
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);

    // Test 6: every entry mismatches; the 2-bit counter instance saturates.
    start_run();
    run_until(0);
    push_expected();
    finish_run("t6", 6);
    check("t6_err_fixed", 32'(error_count), 32'd6);
    check("t6_sat_err", 32'(error_count2), 32'd3);
    check("t6_sat_ffidx", 32'(first_fail_idx2), 32'd0);
    check("t6_sat_pass", 32'(pass2), 32'd0);
    check("t6_sat_done", 32'(done2), 32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
